// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_share_arbiter
//  Purpose  : Round-robin scheduler sharing one pipelined 4x4 multiplier among
//             NREQ requesters. Issues at most one op per cycle, tracks owners
//             through a tag pipeline aligned to the multiplier latency and
//             returns each 8-bit product to the requester that issued it.
//  Revision : 1.0  initial release
// ============================================================================
module mul_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int MUL_LAT = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [4*NREQ-1:0]   req_a,
   input  logic [4*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic [3:0]          mul_a,
   output logic [3:0]          mul_b,
   input  logic [7:0]          mul_prod,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [7:0]          rsp_prod,
   output logic [3:0]          inflight,
   output logic                idle
);

   // One tag per edge between issue register load and response register load
   localparam int TAGS = MUL_LAT + 1;

   logic [2:0] ptr;
   logic       grant_any;
   logic [2:0] grant_id;
   logic [3:0] idx;
   logic [7:0] valid_ext;
   logic [3:0] sel_a;
   logic [3:0] sel_b;
   logic [2:0] ptr_next;

   logic       tag_v  [TAGS];
   logic [2:0] tag_id [TAGS];
   logic       head_v;

   // Round-robin search starting at ptr; en=0 suppresses any grant
   always_comb begin
      valid_ext = 8'(req_valid);
      grant_any = 1'b0;
      grant_id  = 3'd0;
      idx       = 4'd0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
         if (!grant_any && valid_ext[idx[2:0]]) begin
            grant_any = 1'b1;
            grant_id  = idx[2:0];
         end
      end
      if (!en) grant_any = 1'b0;
   end

   // One-hot ready and operand selection for the granted requester
   always_comb begin
      sel_a = 4'd0;
      sel_b = 4'd0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = grant_any && (grant_id == 3'(i));
         if (grant_id == 3'(i)) begin
            sel_a = req_a[4*i +: 4];
            sel_b = req_b[4*i +: 4];
         end
      end
      ptr_next = (grant_id == 3'(NREQ-1)) ? 3'd0 : grant_id + 3'd1;
   end

   assign head_v = tag_v[TAGS-1];
   assign idle   = (inflight == 4'd0) && !(|req_valid);

   // Pointer advance and operand issue register (zero when nothing issues)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr   <= 3'd0;
         mul_a <= 4'd0;
         mul_b <= 4'd0;
      end else if (grant_any) begin
         ptr   <= ptr_next;
         mul_a <= sel_a;
         mul_b <= sel_b;
      end else begin
         mul_a <= 4'd0;
         mul_b <= 4'd0;
      end
   end

   // Owner tag shift register; the head lines up with mul_prod of its op
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < TAGS; i++) begin
            tag_v[i]  <= 1'b0;
            tag_id[i] <= 3'd0;
         end
      end else begin
         tag_v[0]  <= grant_any;
         tag_id[0] <= grant_id;
         for (int i = 1; i < TAGS; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   // Response strobe to the owner; product holds when no response is due
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= '0;
         rsp_prod  <= 8'd0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] <= head_v && (tag_id[TAGS-1] == 3'(i));
         end
         if (head_v) rsp_prod <= mul_prod;
      end
   end

   // Outstanding-op counter: +1 on issue, -1 on response, both cancel
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= 4'd0;
      end else begin
         case ({grant_any, head_v})
            2'b10:   inflight <= inflight + 4'd1;
            2'b01:   inflight <= inflight - 4'd1;
            default: inflight <= inflight;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_share_arbiter
//  Purpose  : Directed self-checking bench for mul_share_arbiter with a
//             MUL_LAT-deep registered multiplier model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_share_arbiter;

   localparam int NREQ    = 4;
   localparam int MUL_LAT = 5;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              en;
   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [3:0]        mul_a;
   logic [3:0]        mul_b;
   logic [7:0]        mul_prod;
   logic [NREQ-1:0]   rsp_valid;
   logic [7:0]        rsp_prod;
   logic [3:0]        inflight;
   logic              idle;

   int checks   = 0;
   int failures = 0;

   int rsp_id_q[$];
   int rsp_pr_q[$];

   logic [7:0] mpipe [MUL_LAT];

   mul_share_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_prod  (mul_prod),
      .rsp_valid (rsp_valid),
      .rsp_prod  (rsp_prod),
      .inflight  (inflight),
      .idle      (idle)
   );

   always #5 clk = ~clk;

   // Multiplier model: registered delay of the product, never reset
   always @(posedge clk) begin
      mpipe[0] <= 8'(mul_a) * 8'(mul_b);
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_prod = mpipe[MUL_LAT-1];

   // Response logger: id 99 marks a strobe that is not one-hot
   always @(negedge clk) begin
      if (rsp_valid != '0) begin
         int id;
         int ones;
         id   = 99;
         ones = 0;
         for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid[i]) begin
               ones++;
               id = i;
            end
         end
         if (ones != 1) id = 99;
         rsp_id_q.push_back(id);
         rsp_pr_q.push_back(int'(rsp_prod));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
      req_a[4*i +: 4] = a;
      req_b[4*i +: 4] = b;
   endtask

   task automatic clear_log();
      rsp_id_q.delete();
      rsp_pr_q.delete();
   endtask

   task automatic check_rsp(input string tag, input int n, input int exp_id, input int exp_pr);
      if (n < rsp_id_q.size()) begin
         check({tag, "_id"}, 32'(rsp_id_q[n]), 32'(exp_id));
         check({tag, "_prod"}, 32'(rsp_pr_q[n]), 32'(exp_pr));
      end else begin
         check({tag, "_missing"}, 32'(rsp_id_q.size()), 32'(n + 1));
      end
   endtask

   initial begin
      logic [3:0] exp_rdy;
      int         exp_inf;

      reset_n   = 1'b1;
      en        = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;

      // ---- reset: asynchronous assertion mid-cycle ----
      #3 reset_n = 1'b0;
      #1;
      check("rst_mul_a", 32'(mul_a), 0);
      check("rst_mul_b", 32'(mul_b), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_prod", 32'(rsp_prod), 0);
      check("rst_inflight", 32'(inflight), 0);
      check("rst_idle", 32'(idle), 1);
      tick();
      tick();
      reset_n = 1'b1;
      en      = 1'b1;
      tick();

      // ---- single op from requester 2: 3*5 ----
      clear_log();
      set_ops(2, 4'd3, 4'd5);
      req_valid = 4'b0100;
      #1;
      check("single_ready", 32'(req_ready), 32'b0100);
      check("single_busy_idle", 32'(idle), 0);
      tick();
      req_valid = '0;
      check("single_mul_a", 32'(mul_a), 3);
      check("single_mul_b", 32'(mul_b), 5);
      check("single_inflight1", 32'(inflight), 1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("single_rsp_valid", 32'(rsp_valid), (k == 6) ? 32'b0100 : 32'b0);
         check("single_inflight", 32'(inflight), (k >= 6) ? 32'd0 : 32'd1);
         if (k == 6) check("single_rsp_prod", 32'(rsp_prod), 15);
      end
      check("single_idle", 32'(idle), 1);

      // ---- fairness after gap: ptr is 3 here ----
      clear_log();
      set_ops(3, 4'd1, 4'd2);
      set_ops(0, 4'd2, 4'd2);
      req_valid = 4'b1000;
      #1;
      check("fair_ready_3", 32'(req_ready), 32'b1000);
      tick();
      req_valid = 4'b1001;
      #1;
      check("fair_ready_0", 32'(req_ready), 32'b0001);
      tick();
      req_valid = 4'b1000;
      #1;
      check("fair_ready_3b", 32'(req_ready), 32'b1000);
      tick();
      req_valid = '0;
      repeat (8) tick();
      check("fair_count", 32'(rsp_id_q.size()), 3);
      check_rsp("fair_r0", 0, 3, 2);
      check_rsp("fair_r1", 1, 0, 4);
      check_rsp("fair_r2", 2, 3, 2);
      check("fair_inflight", 32'(inflight), 0);

      // ---- full contention: ptr is 0 here ----
      clear_log();
      for (int i = 0; i < NREQ; i++) set_ops(i, 4'(i + 12), 4'd15);
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 12; k++) begin
         exp_rdy = 4'b0001 << (k % 4);
         check("cont_ready", 32'(req_ready), 32'(exp_rdy));
         tick();
         exp_inf = (k + 1 < 6) ? k + 1 : 6;
         check("cont_inflight", 32'(inflight), 32'(exp_inf));
      end
      req_valid = '0;
      repeat (8) tick();
      check("cont_count", 32'(rsp_id_q.size()), 12);
      for (int n = 0; n < 12; n++) begin
         check_rsp("cont_r", n, n % 4, (n % 4 + 12) * 15);
      end
      check("cont_drained", 32'(inflight), 0);

      // ---- enable drain: 3 accepts then en=0 ----
      clear_log();
      for (int i = 0; i < NREQ; i++) set_ops(i, 4'(i + 1), 4'd2);
      req_valid = 4'b1111;
      repeat (3) tick();
      en = 1'b0;
      #1;
      check("drain_ready_off", 32'(req_ready), 0);
      check("drain_inflight3", 32'(inflight), 3);
      repeat (10) tick();
      check("drain_ready_still", 32'(req_ready), 0);
      check("drain_mul_a", 32'(mul_a), 0);
      check("drain_inflight0", 32'(inflight), 0);
      check("drain_count", 32'(rsp_id_q.size()), 3);
      check_rsp("drain_r0", 0, 0, 2);
      check_rsp("drain_r1", 1, 1, 4);
      check_rsp("drain_r2", 2, 2, 6);
      req_valid = '0;
      en        = 1'b1;
      tick();

      // ---- reset mid-flight: 4 accepts, reset before first response ----
      clear_log();
      for (int i = 0; i < NREQ; i++) set_ops(i, 4'(i + 12), 4'd15);
      req_valid = 4'b1111;
      #1;
      check("mid_ready_first", 32'(req_ready), 32'b1000);
      repeat (4) tick();
      req_valid = '0;
      check("mid_inflight4", 32'(inflight), 4);
      tick();
      reset_n = 1'b0;
      #1;
      check("mid_rst_inflight", 32'(inflight), 0);
      tick();
      reset_n = 1'b1;
      repeat (10) tick();
      check("mid_no_rsp", 32'(rsp_id_q.size()), 0);
      check("mid_inflight0", 32'(inflight), 0);
      req_valid = 4'b1111;
      #1;
      check("mid_post_grant", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      repeat (8) tick();
      check("mid_post_count", 32'(rsp_id_q.size()), 1);
      check_rsp("mid_post_r0", 0, 0, 180);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin scheduler that shares one pipelined 4x4 multiplier (5-stage Dadda core) among NREQ requesters. It issues at most one operation per cycle into the multiplier and tracks each operation's owner through a tag pipeline matched to the multiplier latency. It returns each 8-bit product to the requester that issued it. It sits between requester blocks and the single multiplier instance; the multiplier itself is external.

## Interface
- NREQ, 4: number of requesters (2..8).
- MUL_LAT, 5: multiplier latency in rising edges, from the edge that samples mul_a/mul_b to the edge after which mul_prod holds that product.
- clk  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  issue enable; when 0 no new grants, in-flight ops still drain.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  4*NREQ  operand A, requester i on bits [4i+3:4i].
- req_b  in  4*NREQ  operand B, same packing.
- req_ready  out  NREQ  one-hot (or zero) grant, combinational from req_valid, en and RR pointer.
- mul_a  out  4  registered operand A to the multiplier.
- mul_b  out  4  registered operand B to the multiplier.
- mul_prod  in  8  multiplier result.
- rsp_valid  out  NREQ  one-hot single-cycle response strobe, registered.
- rsp_prod  out  8  registered product, valid when any rsp_valid bit is set.
- inflight  out  4  ops accepted but not yet responded.
- idle  out  1  high when inflight==0 and no bit of req_valid is set.

## Operation
- Accept for requester i occurs on a rising edge where req_valid[i] & req_ready[i] are both high.
- Arbitration:
  - 3-bit pointer ptr, reset 0.
  - Search starts at ptr, wrapping modulo NREQ; the first requester with req_valid set is granted.
  - On grant g: ptr <= (g+1) mod NREQ.
  - With no grant, ptr holds.
  - en=0 forces req_ready=0.
- Issue:
  - On accept, mul_a/mul_b <= the granted requester's operands.
  - In cycles with no accept, mul_a/mul_b <= 0.
- Tag pipeline:
  - MUL_LAT+1 entries, each {valid, id}.
  - Entry 0 loads {accept, g} every edge; the entries shift one per edge.
  - The head entry is aligned with mul_prod for that op.
- Response:
  - When the head is valid, rsp_valid[id] <= 1 and rsp_prod <= mul_prod.
  - Otherwise rsp_valid <= 0 and rsp_prod holds its value.
- Responses return in issue order.
- No backpressure on responses: requesters must consume the strobe.
- inflight:
  - Increments by 1 on accept and decrements by 1 on a response edge.
  - Both on the same edge: unchanged.
  - Range 0..MUL_LAT+1; never wraps.
- Operands wider than 4 bits do not exist; products are full 8-bit (max 15*15=225), no truncation.

## Timing
- Reset (async assert, synchronous release on clk) clears:
  - mul_a=0, mul_b=0, rsp_valid=0, rsp_prod=0, inflight=0.
  - ptr=0 and all tag valids.
  - idle follows the inputs.
- Reset mid-operation discards all in-flight ops: no rsp_valid for them after release, and the multiplier's stale outputs are ignored because the tags are invalid.
- Accept at edge E0 gives rsp_valid high in the cycle following edge E0+MUL_LAT+1, so request-to-response latency = MUL_LAT+1 = 6 cycles.
- Throughput is one op per cycle sustained; the same requester may be granted on consecutive cycles only if no other requester is valid.
- req_ready depends on the current-cycle req_valid. Requesters hold req_valid and their operands stable until accepted.
- When en falls, the grant is removed in that same cycle (combinational); ops already accepted complete normally.
- A requester that drops req_valid before accept has its request withdrawn, with no side effects.

## Test plan
Bench models the multiplier as an MUL_LAT-deep registered delay of mul_a*mul_b.
- Reset check: assert reset_n=0 mid-cycle -> immediately mul_a=0, mul_b=0, rsp_valid=0, rsp_prod=0, inflight=0; idle=1 with no requests.
- Single op: requester 2 issues A=3, B=5 accepted at E0 -> rsp_valid=4'b0100 with rsp_prod=15 exactly 6 cycles later, one cycle wide; inflight goes 1 then 0.
- Full contention: all 4 valid continuously with A=i+12, B=15, en=1 -> grants 0,1,2,3,0,... one per cycle. Responses arrive in the same order with products 180,195,210,225; inflight saturates at 6.
- Fairness after gap: only requester 3 valid, then requesters 0 and 3 together -> next grant is 0 (ptr wrapped to 0), then 3.
- Enable drain: 3 ops accepted, then en=0 with requests still valid -> req_ready=0. All 3 responses are delivered, inflight reaches 0, and no new accepts occur.
- Reset mid-flight: 4 ops accepted, reset_n pulsed low for 1 cycle before any response -> no rsp_valid ever asserted for them and inflight=0. The first post-reset grant goes to requester 0.
